seg7_scan_mux: RTL

// - Time-multiplexed driver for a common-segment, NUM_DIGITS-digit 7-segment display.
// - Upstream: a hex value and decimal points from user logic. Each scan slot selects one nibble and decodes it.
// - Drives active-low segments a..g (seg[0]=a, seg[6]=g), the dp, and one digit enable at a time.
// - Inter-digit blanking prevents ghosting. Values are double-buffered so a digit never tears mid-frame.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/hex_seg_decode.sv | 32 +++
 rtl/seg7_scan_mux.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h7F;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n > 32'd1 ? n : 32'd2);
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Hex nibble to active-low gfedcba segment pattern (0-9, A b C d E F).
module hex_seg_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = SEG_OFF;
    unique case (nibble)
      4'h0: seg_c = 7'h40;
      4'h1: seg_c = 7'h79;
      4'h2: seg_c = 7'h24;
      4'h3: seg_c = 7'h30;
      4'h4: seg_c = 7'h19;
      4'h5: seg_c = 7'h12;
      4'h6: seg_c = 7'h02;
      4'h7: seg_c = 7'h78;
      4'h8: seg_c = 7'h00;
      4'h9: seg_c = 7'h10;
      4'hA: seg_c = 7'h08;
      4'hB: seg_c = 7'h03;
      4'hC: seg_c = 7'h46;
      4'hD: seg_c = 7'h21;
      4'hE: seg_c = 7'h06;
      4'hF: seg_c = 7'h0E;
      default: seg_c = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scanned NUM_DIGITS-digit 7-segment driver with inter-digit blanking,
// frame-synchronous double buffering and leading-zero suppression.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned DWELL_CYCLES  = 12000,
  parameter int unsigned BLANK_CYCLES  = 200,
  parameter bit          DIGIT_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CW      = cnt_w(CNT_MAX);
  localparam int unsigned IW      = cnt_w(NUM_DIGITS);
  localparam int unsigned VW      = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 32'd1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 32'd0 : BLANK_CYCLES - 32'd1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 32'd1);
  localparam state_t        ST_RESET   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = {NUM_DIGITS{DIGIT_ACT_LOW}};

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || DWELL_CYCLES < 1) begin : g_param_check
    $fatal(1, "seg7_scan_mux: NUM_DIGITS must be 1..8 and DWELL_CYCLES >= 1");
  end

  state_t                  state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [CW-1:0]           cnt, cnt_nx;
  logic [VW-1:0]           shadow_val, shadow_val_nx;
  logic [NUM_DIGITS-1:0]   shadow_dp, shadow_dp_nx;
  logic                    pending, pending_nx;
  logic [VW-1:0]           disp_val, disp_val_nx;
  logic [NUM_DIGITS-1:0]   disp_dp, disp_dp_nx;
  logic                    advance;
  logic                    boundary;

  logic [3:0]              nibble;
  seg_t                    dec_seg;
  logic                    lz_zero;
  logic                    suppress;
  logic [NUM_DIGITS-1:0]   onehot;
  seg_t                    seg_d;
  logic                    dp_n_d;
  logic [NUM_DIGITS-1:0]   en_d;
  logic                    tick_d;

  // State, buffers and output registers; display outputs only move on state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RESET;
      idx        <= '0;
      cnt        <= '0;
      shadow_val <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      seg        <= SEG_OFF;
      dp_n       <= 1'b1;
      digit_en   <= EN_OFF;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      shadow_val <= shadow_val_nx;
      shadow_dp  <= shadow_dp_nx;
      pending    <= pending_nx;
      disp_val   <= disp_val_nx;
      disp_dp    <= disp_dp_nx;
      if (advance) begin
        seg      <= seg_d;
        dp_n     <= dp_n_d;
        digit_en <= en_d;
      end
      frame_tick <= tick_d;
    end
  end

  // Scan sequencing and shadow/display buffer hand-over.
  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    cnt_nx        = cnt + CW'(1);
    shadow_val_nx = shadow_val;
    shadow_dp_nx  = shadow_dp;
    pending_nx    = pending;
    disp_val_nx   = disp_val;
    disp_dp_nx    = disp_dp;
    advance       = (state == ST_SHOW) ? (cnt == DWELL_LAST) : (cnt == BLANK_LAST);
    boundary      = (state == ST_SHOW) && advance && (idx == IDX_LAST);

    if (advance) begin
      cnt_nx = '0;
      if (state == ST_SHOW) begin
        idx_nx   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
        state_nx = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      end else begin
        state_nx = ST_SHOW;
      end
    end

    if (load) begin
      shadow_val_nx = value;
      shadow_dp_nx  = dp;
      pending_nx    = 1'b1;
    end

    // A load coinciding with the boundary bypasses the shadow entirely.
    if (boundary) begin
      if (load) begin
        disp_val_nx = value;
        disp_dp_nx  = dp;
        pending_nx  = 1'b0;
      end else if (pending) begin
        disp_val_nx = shadow_val;
        disp_dp_nx  = shadow_dp;
        pending_nx  = 1'b0;
      end
    end
  end

  assign nibble = disp_val_nx[{idx_nx, 2'b00} +: 4];

  hex_seg_decode u_decode (
    .nibble (nibble),
    .seg_c  (dec_seg)
  );

  // Output values for the state/idx being entered.
  always_comb begin
    lz_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (IW'(i) >= idx_nx && disp_val_nx[4*i +: 4] != 4'h0) lz_zero = 1'b0;
    end
    suppress = blank_lz && (idx_nx != '0) && lz_zero;
    onehot   = NUM_DIGITS'(1) << idx_nx;

    seg_d  = SEG_OFF;
    dp_n_d = 1'b1;
    en_d   = EN_OFF;
    if (state_nx == ST_SHOW) begin
      dp_n_d = ~disp_dp_nx[idx_nx];
      if (!suppress) seg_d = dec_seg;
      if (!suppress || disp_dp_nx[idx_nx]) en_d = onehot ^ EN_OFF;
    end

    // High during the final cycle of the last digit, so the boundary edge ends it.
    tick_d = (state_nx == ST_SHOW) && (idx_nx == IDX_LAST) && (cnt_nx == DWELL_LAST);
  end

endmodule
